my_calculator: RTL and testbench

MY_CALCULATOR -- requirements
Module: my_calculator

---
 rtl/my_calculator_pkg.sv | 35 +++
 rtl/my_calculator_if.sv | 25 ++
 rtl/my_calculator_table.sv | 67 ++++++
 rtl/my_calculator.sv | 87 ++++++++
 tb/tb_my_calculator.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/my_calculator_pkg.sv
// Shared types and constants for the my_calculator sigmoid estimator (Q8.24 fixed point).
// Build option: define MY_CALCULATOR_ROUND_EN to round the interpolation product instead of truncating.
package my_calculator_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 24;
  localparam int ADDR_W = 8;

  // Full-precision interpolation product: 33-bit signed difference times 24-bit fraction.
  localparam int PROD_W = DATA_W + FRAC_W + 1;

  typedef logic signed [DATA_W-1:0] q8_24_t;
  typedef logic signed [ADDR_W-1:0] addr_t;
  typedef logic        [FRAC_W-1:0] frac_t;

  localparam int     S_MIN_IDX = -16;
  localparam int     S_MAX_IDX = 15;
  localparam q8_24_t S_ONE     = 32'sh0100_0000;

  typedef struct packed {
    q8_24_t base;
    q8_24_t next_data;
    frac_t  remaining;
  } stage1_t;

  // Integer part of a Q8.24 value, taken as floor so negative inputs index correctly.
  function automatic addr_t q_int_part(input q8_24_t z);
    return addr_t'(z[DATA_W-1:FRAC_W]);
  endfunction

  function automatic frac_t q_frac_part(input q8_24_t z);
    return z[FRAC_W-1:0];
  endfunction

endpackage

// File: rtl/my_calculator_if.sv
// Sample-in / estimate-out bus of my_calculator; the driver uses master, the calculator uses slave.
// Build option MY_CALCULATOR_ROUND_EN does not change this interface.
interface my_calculator_if;
  import my_calculator_pkg::*;

  logic   in_valid;
  q8_24_t z_value;
  logic   out_valid;
  q8_24_t estimated_value;

  modport master (
    output in_valid,
    output z_value,
    input  out_valid,
    input  estimated_value
  );

  modport slave (
    input  in_valid,
    input  z_value,
    output out_valid,
    output estimated_value
  );

endinterface

// File: rtl/my_calculator_table.sv
// my_table: combinational sigmoid ROM returning S(addr) and S(addr+1) in Q8.24.
// Contents are identical whether or not MY_CALCULATOR_ROUND_EN is defined.
module my_table
  import my_calculator_pkg::*;
(
  input  addr_t  i_addr,
  output q8_24_t o_base,
  output q8_24_t o_next_data
);

  // S(i) = round-half-up(sigmoid(i) * 2^24); saturates to 0 / S_ONE outside the stored range.
  function automatic q8_24_t s_lookup(input int idx);
    q8_24_t v;
    v = '0;
    if (idx < S_MIN_IDX) begin
      v = '0;
    end else if (idx > S_MAX_IDX) begin
      v = S_ONE;
    end else begin
      case (idx)
        -16: v = 32'sd2;
        -15: v = 32'sd5;
        -14: v = 32'sd14;
        -13: v = 32'sd38;
        -12: v = 32'sd103;
        -11: v = 32'sd280;
        -10: v = 32'sd762;
        -9:  v = 32'sd2070;
        -8:  v = 32'sd5626;
        -7:  v = 32'sd15285;
        -6:  v = 32'sd41484;
        -5:  v = 32'sd112287;
        -4:  v = 32'sd301759;
        -3:  v = 32'sd795674;
        -2:  v = 32'sd1999893;
        -1:  v = 32'sd4512088;
        0:   v = 32'sd8388608;
        1:   v = 32'sd12265128;
        2:   v = 32'sd14777323;
        3:   v = 32'sd15981542;
        4:   v = 32'sd16475457;
        5:   v = 32'sd16664929;
        6:   v = 32'sd16735732;
        7:   v = 32'sd16761931;
        8:   v = 32'sd16771590;
        9:   v = 32'sd16775146;
        10:  v = 32'sd16776454;
        11:  v = 32'sd16776936;
        12:  v = 32'sd16777113;
        13:  v = 32'sd16777178;
        14:  v = 32'sd16777202;
        15:  v = 32'sd16777211;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  logic w_is_top;

  assign w_is_top = (i_addr == addr_t'(127));
  assign o_base   = s_lookup(int'(i_addr));

  // The top index must not wrap to -128; its neighbour is defined as itself.
  assign o_next_data = w_is_top ? o_base : s_lookup(int'(i_addr) + 1);

endmodule

// File: rtl/my_calculator.sv
// my_calculator: two-stage pipelined sigmoid estimator, table lookup plus linear interpolation.
// Define MY_CALCULATOR_ROUND_EN to round the product to nearest; default build truncates.
module my_calculator
  import my_calculator_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  my_calculator_if.slave calc_bus
);

  addr_t   w_addr;
  frac_t   w_remaining;
  q8_24_t  w_base;
  q8_24_t  w_next_data;

  stage1_t r_s1;
  logic    r_s1_valid;
  q8_24_t  r_estimated_value;
  logic    r_out_valid;

  assign w_addr      = q_int_part(calc_bus.z_value);
  assign w_remaining = q_frac_part(calc_bus.z_value);

  my_table u_table (
    .i_addr      (w_addr),
    .o_base      (w_base),
    .o_next_data (w_next_data)
  );

  // Stage 1: latch table outputs and fraction alongside the valid flag.
  // NOTE: every pipeline register is cleared by reset so in-flight samples are discarded, not just flagged off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep both stages reading pre-edge values.
      r_s1_valid <= calc_bus.in_valid;
      if (calc_bus.in_valid) begin
        r_s1.base      <= w_base;
        r_s1.next_data <= w_next_data;
        r_s1.remaining <= w_remaining;
      end
    end
  end

  logic signed [DATA_W:0]   w_diff;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_prod_adj;
  logic signed [PROD_W-1:0] w_shifted;
  q8_24_t                   w_estimate;
  logic                     w_unused_bits;

`ifdef MY_CALCULATOR_ROUND_EN
  localparam logic signed [PROD_W-1:0] ROUND_K =
    {{(PROD_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
`else
  localparam logic signed [PROD_W-1:0] ROUND_K = '0;
`endif

  assign w_diff     = $signed({r_s1.next_data[DATA_W-1], r_s1.next_data})
                    - $signed({r_s1.base[DATA_W-1], r_s1.base});
  assign w_prod     = PROD_W'(w_diff) * $signed(PROD_W'({1'b0, r_s1.remaining}));
  assign w_prod_adj = w_prod + ROUND_K;
  assign w_shifted  = w_prod_adj >>> FRAC_W;

  // The shifted term is at most 2^24, so only the low word contributes to the sum.
  assign w_estimate    = r_s1.base + w_shifted[DATA_W-1:0];
  assign w_unused_bits = ^w_shifted[PROD_W-1:DATA_W];

  // Stage 2: the estimate only updates with a valid sample and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estimated_value <= '0;
      r_out_valid       <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_estimated_value <= w_estimate;
      end
    end
  end

  assign calc_bus.out_valid       = r_out_valid;
  assign calc_bus.estimated_value = r_estimated_value;

endmodule

// File: tb/tb_my_calculator.sv
// Self-checking bench for my_calculator: directed spec vectors, reset abort, then random traffic.
// Expected values come from a real-arithmetic sigmoid model; follows MY_CALCULATOR_ROUND_EN if defined.
module tb_my_calculator;
  import my_calculator_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  my_calculator_if calc_bus ();

  my_calculator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .calc_bus (calc_bus)
  );

  always #5 clk = ~clk;

  int     n_vec  = 0;
  int     n_miss = 0;
  int     cyc    = 0;
  bit     exp_v[int];
  longint exp_d[int];
  longint last_est = 0;

  // S(i) from the sigmoid definition, rounded half-up to Q8.24.
  function automatic longint s_ref(input int i);
    real sv;
    if (i < -16) return 0;
    if (i >= 16) return 64'd16777216;
    sv = 16777216.0 / (1.0 + $exp(-1.0 * i));
    return longint'($floor(sv + 0.5));
  endfunction

  function automatic longint est_ref(input logic [31:0] z);
    int     a;
    longint rem, base, nxt, prod;
    a    = int'($signed(z[31:24]));
    rem  = longint'(z[23:0]);
    base = s_ref(a);
    nxt  = (a == 127) ? base : s_ref(a + 1);
    prod = (nxt - base) * rem;
`ifdef MY_CALCULATOR_ROUND_EN
    prod = prod + 64'd8388608;
`endif
    return base + (prod >>> 24);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s (cycle %0d): observed 0x%0h expected 0x%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_outputs();
    if (exp_v.exists(cyc)) begin
      check("out_valid", 64'(calc_bus.out_valid), 64'd1);
      check("estimate", 64'(calc_bus.estimated_value), 64'(exp_d[cyc]));
      last_est = exp_d[cyc];
      exp_v.delete(cyc);
      exp_d.delete(cyc);
    end else begin
      check("idle_valid", 64'(calc_bus.out_valid), 64'd0);
      check("hold_estimate", 64'(calc_bus.estimated_value), 64'(last_est));
    end
  endtask

  // Drive one sample for the coming edge, then check the outputs just after it.
  task automatic step(input bit v, input logic [31:0] z);
    calc_bus.in_valid = v;
    calc_bus.z_value  = z;
    if (v && rst_n) begin
      exp_v[cyc + 2] = 1'b1;
      exp_d[cyc + 2] = est_ref(z);
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  initial begin
    int          ai;
    logic [31:0] z;
    bit          v;

    calc_bus.in_valid = 1'b0;
    calc_bus.z_value  = '0;
    #1;
    check("reset_valid", 64'(calc_bus.out_valid), 64'd0);
    check("reset_estimate", 64'(calc_bus.estimated_value), 64'd0);
    repeat (3) step(1'b0, 32'h0);
    rst_n = 1'b1;

    // First sample after reset, then the directed table and boundary points.
    step(1'b1, 32'h0000_0000);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    step(1'b1, 32'h015F_FB80);
    step(1'b1, 32'hF800_0000);
    step(1'b1, 32'h7F80_0000);
    step(1'b1, 32'h7FFF_FFFF);
    step(1'b1, 32'h8000_0000);
    step(1'b1, 32'h0F80_0000);
    step(1'b1, 32'hEFFF_FFFF);
    step(1'b1, 32'h0080_0000);
    step(1'b1, 32'h0000_0001);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);

    // Back-to-back samples produce consecutive results in order.
    step(1'b1, 32'h0000_0000);
    step(1'b1, 32'h0100_0000);
    step(1'b1, 32'hFF00_0000);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);

    // Reset with stage 1 and the output register both occupied.
    step(1'b1, 32'h0200_0000);
    step(1'b1, 32'h0300_0000);
    calc_bus.in_valid = 1'b1;
    calc_bus.z_value  = 32'h0400_0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(calc_bus.out_valid), 64'd0);
    check("abort_estimate", 64'(calc_bus.estimated_value), 64'd0);
    exp_v.delete();
    exp_d.delete();
    last_est = 0;
    repeat (2) step(1'b0, 32'h0);
    rst_n = 1'b1;
    repeat (4) step(1'b0, 32'h0);
    step(1'b1, 32'hFE80_0000);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);

    // Random traffic with gaps, concentrated on the interesting index range.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 4) != 0;
      case ($urandom % 4)
        0: z = $urandom;
        1: begin
          ai = int'($urandom_range(40)) - 20;
          z  = {ai[7:0], 24'($urandom)};
        end
        2: z = {8'($urandom), 24'h0};
        default: begin
          ai = int'($urandom_range(34)) - 17;
          z  = {ai[7:0], (($urandom % 2) != 0) ? 24'hFF_FFFF : 24'h00_0001};
        end
      endcase
      step(v, z);
    end
    repeat (3) step(1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
